gbe_rx_snap_ctrl: RTL



---
 rtl/gbe_rx_snap_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/gbe_rx_snap_ctrl.sv
// gbe_rx_snap_ctrl
// Capture sequencer for the receive snapshot buffer. Waits for an arm command
// and an optional trigger, then streams valid receive words into BRAM port A
// until the buffer fills or software stops the capture. Publishes busy/done,
// word count and last written address for the register interface.
module gbe_rx_snap_ctrl #(
    parameter int AW = 13,
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ctrl_arm,
    input  logic          ctrl_stop,
    input  logic          ctrl_trig_en,
    input  logic          din_valid,
    input  logic          din_trig,
    input  logic [DW-1:0] din_data,
    output logic          bram_we,
    output logic          bram_en_a,
    output logic [AW-1:0] bram_addr,
    output logic [DW-1:0] bram_wr_data,
    output logic          status_busy,
    output logic          status_done,
    output logic [AW:0]   status_count,
    output logic [AW-1:0] status_last_addr
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Count value just before the write that fills the buffer.
    localparam logic [AW:0]   COUNT_LAST = {1'b0, {AW{1'b1}}};
    localparam logic [AW:0]   COUNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic            trig_en_q, trig_en_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW:0]     count_q, count_d;
    logic [AW-1:0]   last_addr_q, last_addr_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            write_s;

    // Next-state, write-request and status computation.
    always_comb begin
        state_d     = state_q;
        trig_en_d   = trig_en_q;
        wptr_d      = wptr_q;
        count_d     = count_q;
        last_addr_d = last_addr_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_s     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // A new arm restarts the buffer; last address is kept until
                // the first new word lands.
                if (ctrl_arm) begin
                    state_d   = ST_ARMED;
                    count_d   = {(AW+1){1'b0}};
                    wptr_d    = {AW{1'b0}};
                    trig_en_d = ctrl_trig_en;
                end else begin
                    state_d = state_q;
                end
            end
            ST_ARMED: begin
                if (ctrl_stop) begin
                    state_d = ST_IDLE;
                    count_d = {(AW+1){1'b0}};
                end else if (din_valid && (!trig_en_q || din_trig)) begin
                    write_s = 1'b1;
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_CAPTURE: begin
                // A word coincident with stop is still written.
                if (din_valid) begin
                    write_s = 1'b1;
                end else begin
                    write_s = 1'b0;
                end
                if (ctrl_stop) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (write_s) begin
            we_d        = 1'b1;
            addr_d      = wptr_q;
            wdata_d     = din_data;
            wptr_d      = wptr_q + PTR_ONE;
            count_d     = count_q + COUNT_ONE;
            last_addr_d = wptr_q;
            // This write fills the buffer: stop capturing.
            if (count_q == COUNT_LAST) begin
                state_d = ST_DONE;
            end else begin
                state_d = state_d;
            end
        end else begin
            we_d = 1'b0;
        end

        busy_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
        done_d = (state_d == ST_DONE);
    end

    // State, pointer, status and BRAM port registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            trig_en_q   <= 1'b0;
            wptr_q      <= {AW{1'b0}};
            count_q     <= {(AW+1){1'b0}};
            last_addr_q <= {AW{1'b0}};
            we_q        <= 1'b0;
            addr_q      <= {AW{1'b0}};
            wdata_q     <= {DW{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            trig_en_q   <= trig_en_d;
            wptr_q      <= wptr_d;
            count_q     <= count_d;
            last_addr_q <= last_addr_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bram_we          = we_q;
    assign bram_en_a        = we_q;
    assign bram_addr        = addr_q;
    assign bram_wr_data     = wdata_q;
    assign status_busy      = busy_q;
    assign status_done      = done_q;
    assign status_count     = count_q;
    assign status_last_addr = last_addr_q;

endmodule
